// File: rtl/johnson_pkg.sv
// Shared constants and types for consumers of the 4-stage Johnson counter.
//   JOHNSON_N   : number of Johnson stages
//   PH          : number of legal phases (2*JOHNSON_N)
//   IDX_W       : width of a binary phase index
//   phase_idx_t : binary phase index type
package johnson_pkg;

  localparam int unsigned JOHNSON_N = 4;
  localparam int unsigned PH        = 2 * JOHNSON_N;
  localparam int unsigned IDX_W     = $clog2(PH);

  typedef logic [IDX_W-1:0] phase_idx_t;

endpackage

// File: rtl/johnson_code_lut.sv
// Combinational Johnson-code decoder, usable by any Johnson-state consumer.
// Ports:
//   jq_r  : Johnson state, bit0 = q1
//   idx   : binary phase index (0 when the code is illegal)
//   legal : jq_r is one of the 2*N legal Johnson codes
module johnson_code_lut
  import johnson_pkg::*;
#(
  parameter int unsigned N = JOHNSON_N
) (
  input  logic [N-1:0]           jq_r,
  output logic [$clog2(2*N)-1:0] idx,
  output logic                   legal
);

  localparam int unsigned IW = $clog2(2 * N);
  localparam logic [N-1:0] Ones = '1;

  always_comb begin
    idx   = '0;
    legal = 1'b0;
    // Fill phase: k ones packed from bit0 -> index k (k = 0..N).
    for (int k = 0; k <= N; k++) begin
      if (jq_r == (Ones >> (N - k))) begin
        idx   = IW'(k);
        legal = 1'b1;
      end
    end
    // Drain phase: k zeros packed from bit0 -> index N+k (k = 1..N-1).
    for (int k = 1; k < N; k++) begin
      if (jq_r == (Ones << k)) begin
        idx   = IW'(N + k);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_phase_decode.sv
// Phase decoder for a Johnson counter. Captures the counter state, decodes it
// into a registered one-hot phase and binary index, counts full rotations and
// flags illegal codes and out-of-order transitions. Latency jq -> phase is 2.
// Optional: define JPD_STALL_DETECT_EN to flag a phase held STALL_MAX cycles;
// otherwise stall_err is tied low.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   jq          : Johnson counter state (bit0 = q1)
//   err_clr     : synchronous clear of the sticky error flags
//   phase       : one-hot phase, zero on an illegal code
//   phase_idx   : binary phase index, holds over illegal codes
//   valid       : phase/phase_idx hold a legal decode
//   rot_pulse   : one-cycle pulse on the last-phase -> phase-0 wrap
//   rot_cnt     : completed rotations, wrapping
//   illegal_err : sticky, non-Johnson code seen
//   seq_err     : sticky, legal code out of sequence
//   stall_err   : sticky, phase held too long
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int unsigned N         = JOHNSON_N,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned STALL_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           jq,
  input  logic                   err_clr,
  output logic [2*N-1:0]         phase,
  output logic [$clog2(2*N)-1:0] phase_idx,
  output logic                   valid,
  output logic                   rot_pulse,
  output logic [CNT_W-1:0]       rot_cnt,
  output logic                   illegal_err,
  output logic                   seq_err,
  output logic                   stall_err
);

  localparam int unsigned NPH = 2 * N;
  localparam int unsigned IW  = $clog2(NPH);

  if (STALL_MAX < 1) begin : g_bad_stall_max
    $error("STALL_MAX must be at least 1");
  end

  logic [N-1:0]  jq_r;
  logic          prev_valid;
  logic [IW-1:0] prev_idx;

  logic [IW-1:0]  dec_idx;
  logic           dec_legal;
  logic [IW-1:0]  prev_next;
  logic           seq_chk;
  logic           is_hold;
  logic           is_step;
  logic           seq_bad;
  logic           is_rot;
  logic [NPH-1:0] phase_dec;

  johnson_code_lut #(
    .N (N)
  ) u_lut (
    .jq_r  (jq_r),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  always_comb begin
    prev_next = (prev_idx == IW'(NPH - 1)) ? '0 : prev_idx + 1'b1;
    // Only a legal code following a legal code is order-checked.
    seq_chk   = prev_valid & dec_legal;
    is_hold   = seq_chk & (dec_idx == prev_idx);
    is_step   = seq_chk & (dec_idx == prev_next);
    seq_bad   = seq_chk & ~is_hold & ~is_step;
    is_rot    = seq_chk & (prev_idx == IW'(NPH - 1)) & (dec_idx == '0);
    phase_dec = dec_legal ? (NPH'(1) << dec_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jq_r        <= '0;
      prev_valid  <= 1'b0;
      prev_idx    <= '0;
      phase       <= '0;
      phase_idx   <= '0;
      valid       <= 1'b0;
      rot_pulse   <= 1'b0;
      rot_cnt     <= '0;
      illegal_err <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      jq_r       <= jq;
      prev_valid <= dec_legal;
      prev_idx   <= dec_idx;
      phase      <= phase_dec;
      valid      <= dec_legal;
      if (dec_legal) begin
        phase_idx <= dec_idx;
      end
      rot_pulse <= is_rot;
      if (is_rot) begin
        rot_cnt <= rot_cnt + 1'b1;
      end
      // New errors win over a simultaneous clear.
      illegal_err <= ~dec_legal | (illegal_err & ~err_clr);
      seq_err     <= seq_bad | (seq_err & ~err_clr);
    end
  end

`ifdef JPD_STALL_DETECT_EN
  localparam int unsigned HoldW = $clog2(STALL_MAX + 1);

  logic [HoldW-1:0] hold_cnt;
  logic [HoldW-1:0] hold_cnt_d;

  // Counts the cycles the current legal phase has been present; the arrival
  // cycle counts as one so that STALL_MAX consecutive samples trip the flag.
  always_comb begin
    hold_cnt_d = '0;
    if (dec_legal) begin
      if (is_hold) begin
        hold_cnt_d = (hold_cnt == HoldW'(STALL_MAX)) ? hold_cnt : hold_cnt + 1'b1;
      end else begin
        hold_cnt_d = HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      stall_err <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_d;
      stall_err <= (hold_cnt_d == HoldW'(STALL_MAX)) | (stall_err & ~err_clr);
    end
  end
`else
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_phase_decode.sv
module tb_johnson_phase_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] jq;
  logic       err_clr;

  logic [7:0] a_phase, b_phase;
  logic [2:0] a_idx, b_idx;
  logic       a_valid, b_valid;
  logic       a_rot_pulse, b_rot_pulse;
  logic [7:0] a_rot_cnt;
  logic [1:0] b_rot_cnt;
  logic       a_ill, b_ill;
  logic       a_seq, b_seq;
  logic       a_stall, b_stall;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic stall_exp;

  logic [3:0] seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  always #5 clk = ~clk;

  johnson_phase_decode dut_a (
    .clk         (clk),
    .rst         (rst),
    .jq          (jq),
    .err_clr     (err_clr),
    .phase       (a_phase),
    .phase_idx   (a_idx),
    .valid       (a_valid),
    .rot_pulse   (a_rot_pulse),
    .rot_cnt     (a_rot_cnt),
    .illegal_err (a_ill),
    .seq_err     (a_seq),
    .stall_err   (a_stall)
  );

  johnson_phase_decode #(
    .CNT_W (2)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .jq          (jq),
    .err_clr     (err_clr),
    .phase       (b_phase),
    .phase_idx   (b_idx),
    .valid       (b_valid),
    .rot_pulse   (b_rot_pulse),
    .rot_cnt     (b_rot_cnt),
    .illegal_err (b_ill),
    .seq_err     (b_seq),
    .stall_err   (b_stall)
  );

  always @(negedge clk) begin
    if (a_rot_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive count codes starting at phase start; outputs lag jq by two edges.
  task automatic run_codes(input int start, input int count);
    for (int j = 0; j < count; j++) begin
      tick();
      if (j >= 2) begin
        chk("walk_phase", a_phase, 8'b1 << ((start + j - 2) % 8));
        chk("walk_valid", a_valid, 1);
      end
      jq = seq[(start + j) % 8];
    end
  endtask

  initial begin
    rst = 1'b1;
    jq = 4'b0101;
    err_clr = 1'b0;
    tick();
    tick();
    chk("rst_phase", a_phase, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_rot_cnt", a_rot_cnt, 0);
    chk("rst_pulse", a_rot_pulse, 0);
    chk("rst_ill", a_ill, 0);
    chk("rst_seq", a_seq, 0);
    tick();
    jq = 4'h0;
    rst = 1'b0;

    // Three rotations, then hold at phase 0.
    run_codes(0, 25);
    tick();
    tick();
    tick();
    chk("rot3_cnt_a", a_rot_cnt, 3);
    chk("rot3_cnt_b", b_rot_cnt, 3);
    chk("rot3_pulses", pulse_cnt, 3);
    chk("hold0_no_pulse", a_rot_pulse, 0);
    chk("rot3_idx", a_idx, 0);

    // Two more rotations: 2-bit counter wraps to 1.
    run_codes(1, 16);
    tick();
    tick();
    tick();
    chk("rot5_cnt_a", a_rot_cnt, 5);
    chk("rot5_cnt_b", b_rot_cnt, 1);
    chk("rot5_pulses", pulse_cnt, 5);
    chk("clean_ill", a_ill, 0);
    chk("clean_seq", a_seq, 0);
    chk("clean_stall", a_stall, 0);

    // Illegal code, then an out-of-order legal code that must not flag.
    tick(); jq = 4'b0101;
    tick(); jq = 4'hC;
    tick();
    chk("ill_valid", a_valid, 0);
    chk("ill_phase", a_phase, 0);
    chk("ill_flag", a_ill, 1);
    chk("ill_idx_hold", a_idx, 0);
    jq = 4'h8;
    tick();
    chk("after_ill_valid", a_valid, 1);
    chk("after_ill_phase", a_phase, 8'h40);
    chk("after_ill_idx", a_idx, 6);
    chk("after_ill_seq", a_seq, 0);
    jq = 4'h0;
    tick();
    chk("ill_sticky", a_ill, 1);
    chk("after_ill_seq2", a_seq, 0);

    // Skip 2 -> 5, then clear.
    tick(); jq = 4'h1;
    tick(); jq = 4'h3;
    tick(); jq = 4'hE;
    tick(); jq = 4'hC;
    tick();
    chk("skip_seq", a_seq, 1);
    chk("skip_idx", a_idx, 5);
    jq = 4'h8;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_seq", a_seq, 0);
    chk("clr_ill", a_ill, 0);
    jq = 4'h0;

    // Skip 1 -> 3 decoded in the same cycle as err_clr: set wins.
    tick(); jq = 4'h1;
    tick(); jq = 4'h7;
    tick(); jq = 4'hF; err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    chk("clr_vs_set_seq", a_seq, 1);
    jq = 4'hE;
    tick();
    chk("seq_sticky", a_seq, 1);
    jq = 4'hC;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    jq = 4'h8;
    tick();
    chk("clr2_seq", a_seq, 0);
    jq = 4'h0;

    // Reset mid-rotation at idx 5.
    tick(); jq = 4'h1;
    tick(); jq = 4'h3;
    tick(); jq = 4'h7;
    tick(); jq = 4'hF;
    tick(); jq = 4'hE;
    tick(); jq = 4'hC;
    tick();
    chk("pre_rst_idx", a_idx, 5);
    chk("pre_rst_rot_cnt", a_rot_cnt, 8);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_phase", a_phase, 0);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_idx", a_idx, 0);
    chk("mid_rst_rot_cnt", a_rot_cnt, 0);
    chk("mid_rst_pulse", a_rot_pulse, 0);
    jq = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    tick(); jq = 4'h1;
    tick(); jq = 4'h3;
    tick(); jq = 4'h7;
    tick();
    chk("resume_phase", a_phase, 8'h04);
    chk("resume_valid", a_valid, 1);
    chk("resume_seq", a_seq, 0);
    chk("resume_rot_cnt", a_rot_cnt, 0);

    // 0111 sampled for 15 cycles, then advance: no stall.
    repeat (13) tick();
    tick(); jq = 4'hF;
    tick(); jq = 4'hE;
    tick(); jq = 4'hC;
    tick(); jq = 4'h8;
    tick(); jq = 4'h0;
    tick(); jq = 4'h1;
    tick(); jq = 4'h3;
    tick();
    chk("hold15_stall", a_stall, 0);
    jq = 4'h7;
    // 0111 sampled for 16 cycles.
    repeat (15) tick();
    tick(); jq = 4'hF;
    tick();
    tick();
`ifdef JPD_STALL_DETECT_EN
    stall_exp = 1'b1;
`else
    stall_exp = 1'b0;
`endif
    chk("hold16_stall", a_stall, stall_exp);
    chk("hold16_seq", a_seq, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("stall_clr", a_stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_phase_decode.md
Name: johnson_phase_decode

Overview:
- Downstream consumer of the 4-stage Johnson counter (`johncount`). Samples the counter's q1..q4 outputs every clock.
- Produces:
  - a registered one-hot phase vector and binary phase index;
  - a rotation counter and a once-per-rotation pulse;
  - sticky error flags for illegal codes and out-of-order transitions.
- Sits between the Johnson counter and phase-sequenced logic (strobes, multiplexed enables).

Parameters:
- N, 4, number of Johnson stages; legal phases PH = 2*N.
- CNT_W, 8, width of the rotation counter.
- STALL_MAX, 16, hold-cycle threshold; used only when JPD_STALL_DETECT_EN is defined.

Ports:
- clk  input  1  rising-edge clock, shared with the Johnson counter.
- rst  input  1  asynchronous, active-high reset.
- jq  input  N  counter state; bit0=q1 ... bit N-1=qN.
- err_clr  input  1  synchronous clear of sticky error flags.
- phase  output  PH  registered one-hot phase; all-zero when the code is illegal.
- phase_idx  output  $clog2(PH)  registered binary phase index.
- valid  output  1  phase/phase_idx hold a legal decode.
- rot_pulse  output  1  one-cycle pulse on a PH-1 -> 0 transition.
- rot_cnt  output  CNT_W  completed rotations; wraps modulo 2^CNT_W.
- illegal_err  output  1  sticky: a non-Johnson code was seen.
- seq_err  output  1  sticky: a legal code arrived out of sequence.
- stall_err  output  1  sticky: the phase was held too long (only with JPD_STALL_DETECT_EN).

Behaviour:
- Reset (async, rst=1): all outputs 0; internal jq_r=0; prev_valid=0; prev_idx=0.
- Stage 1: jq_r <= jq every cycle (capture register).
- Stage 2: decode jq_r; all outputs registered. Latency from jq to phase/valid is 2 clocks.
- Legal codes, N=4: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7.
  - General rule: k ones filling from bit0 -> idx k; then zeros filling from bit0 -> idx N+k.
- Legal code:
  - valid=1, phase[idx]=1, phase_idx=idx.
- Illegal code:
  - valid=0, phase=0.
  - phase_idx holds its last value.
  - illegal_err sets.
- Sequence check: applied only when prev_valid=1 and the current code is legal.
  - Allowed: idx==prev_idx (hold) or idx==(prev_idx+1) mod PH.
  - Anything else sets seq_err.
- prev_valid/prev_idx update every cycle from the current decode.
  - After an illegal code, prev_valid=0, so the first legal code that follows is never flagged as seq_err.
- Rotation: when prev_valid=1, prev_idx=PH-1 and idx=0:
  - rot_pulse=1 for one cycle;
  - rot_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - A hold at idx 0 does not re-pulse.
- err_clr=1 clears illegal_err, seq_err and stall_err on the next edge.
  - If a new error is detected in the same cycle as err_clr, set wins.
- The first legal code after reset is accepted without a sequence check. rot_cnt starts at 0.
- Reset mid-rotation: immediate return to the reset values; no pulse is generated.

Optional Feature:
- Macro: JPD_STALL_DETECT_EN.
- Defined:
  - A hold counter of width $clog2(STALL_MAX+1) counts consecutive cycles with a legal idx equal to prev_idx.
  - The counter resets on any change or illegal code.
  - When the counter reaches STALL_MAX, stall_err sets (sticky; cleared by err_clr).
  - The counter saturates at STALL_MAX.
- Undefined: no hold counter; stall_err is tied to 0 and the port is retained.

Decomposition:
- Package johnson_pkg:
  - localparam PH;
  - IDX_W = $clog2(PH);
  - typedef phase_idx_t.
- Sub-module johnson_code_lut (combinational):
  - inputs: jq_r;
  - outputs: idx and legal.
  - Reused by any other Johnson-state consumer.

Test Plan:
- Reset, then drive the legal sequence 0000,0001,...,1000 from a johncount instance:
  - phase walks 0x01->0x80, lagging jq by 2 clocks;
  - valid=1 throughout; no errors.
- Run 3 full rotations: three rot_pulse events; rot_cnt=3.
  - With CNT_W=2 and 5 rotations: rot_cnt=1.
- Force jq=0101 for one cycle:
  - valid=0 and phase=0 two clocks later;
  - illegal_err=1 and stays set;
  - the next legal code does not set seq_err.
- Jump jq from 0011 (idx2) to 1110 (idx5): seq_err=1.
  - err_clr pulse clears it.
  - err_clr in the same cycle as a new skip leaves seq_err=1.
- Assert rst mid-rotation at idx 5: all outputs 0 immediately; rot_cnt=0.
  - After release, the sequence resumes with no seq_err.
- With JPD_STALL_DETECT_EN and STALL_MAX=16:
  - hold jq at 0111 for 16 cycles -> stall_err=1;
  - hold for 15 cycles then advance -> stall_err=0.
